pc_seq_ctrl: RTL and testbench
==============================

// Module: pc_seq_ctrl
// PURPOSE
//  Next-PC sequencer and trap controller for the single-cycle CPU: owns the instruction
//  address register and selects each cycle among sequential, branch, jump, return,
//  exception and interrupt targets. Tracks handler mode, saves the return address (XP)
//  and masks interrupts while in a handler. Sits between the control unit and imem.
// PARAMETERS
//  RESET_VEC  32'h8000_0000  address loaded on reset and on double fault
//  EXC_VEC    32'h8000_0004  exception handler entry
//  IRQ_VEC    32'h8000_0008  interrupt handler entry
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  reset_n      in   1   synchronous, active-low reset
//  stall        in   1   hold ia (pipeline/memory wait)
//  branch_taken in   1   take branch_target this cycle
//  branch_target in  32  branch destination
//  jump         in   1   take jump_target this cycle
//  jump_target  in   32  jump/jr destination
//  eret         in   1   return from handler to xp
//  Exception    in   1   synchronous exception for the instruction at ia
//  irq          in   1   level interrupt request from outside the core
//  ia           out  32  instruction address (registered)
//  xp           out  32  saved return address (registered)
//  in_handler   out  1   1 while executing a trap handler (irq masked)
//  irq_ack      out  1   one-cycle pulse when an irq is taken
//  double_fault out  1   sticky; Exception raised while in_handler
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): ia=RESET_VEC, xp=0, in_handler=0, irq_ack=0,
//    double_fault=0, state=RUN. Overrides all other inputs, including stall.
//  - States: RUN (normal, irq enabled), HANDLER (in_handler=1, irq masked).
//  - Priority each cycle, highest first: reset > Exception > irq > stall > eret > jump >
//    branch_taken > sequential (ia+4). One source wins; others ignored that cycle.
//  - Exception in RUN: xp<=ia, ia<=EXC_VEC, ->HANDLER. Taken even when stall=1.
//  - Exception in HANDLER: double_fault<=1, ia<=RESET_VEC, xp unchanged, ->RUN.
//  - irq (post-sync) in RUN with stall=0: xp<=ia+4 (interrupted instr completes),
//    ia<=IRQ_VEC, irq_ack=1 for that cycle, ->HANDLER. irq ignored in HANDLER and while
//    stall=1 (remains pending as a level; not latched).
//  - stall=1 (no Exception/reset): ia, xp, state held; eret/jump/branch dropped.
//  - eret in HANDLER: ia<=xp, ->RUN; irq asserted that same cycle is not taken until the
//    next cycle (eret wins only when irq is masked). eret in RUN: treated as NOP (ia+4).
//  - jump beats branch_taken if both asserted. Targets used as-is; low 2 bits forced 0.
//  - ia+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0); no overflow flag.
//  - Latency: every redirect visible on ia the cycle after the deciding posedge.
//  - double_fault clears only on reset.
// CONFIGURATION
//  PC_SEQ_IRQ_SYNC_EN defined: irq passes through 2-flop synchronizer (reset to 0); irq
//   takes effect 2 cycles later than raw; irq pulses <2 cycles may be lost.
//  Not defined: irq sampled directly at posedge (caller guarantees synchronous irq).
// STRUCTURE
//  pc_seq_pkg: vector constants (RESET_VEC/EXC_VEC/IRQ_VEC defaults), state enum
//   {RUN, HANDLER}, pcsel enum {PC_SEQ, PC_BR, PC_JMP, PC_XP, PC_EXC, PC_IRQ, PC_RST}.
//  Sub-module irq_sync (2-flop, sync active-low reset), instantiated under the macro.
//  Body: combinational pcsel priority encoder + one registered state/ia/xp block.
// TESTING
//  1 reset_n=0 2 cycles, release, free-run 3 cycles -> ia 80000000,..04,..08,..0C.
//  2 ia=80000010, branch_taken=1 & jump=1, targets 100/200 -> next ia=200; branch alone
//    target 103 -> ia=100.
//  3 ia=80000020, Exception=1, stall=1 -> ia=80000004, xp=80000020, in_handler=1;
//    then eret -> ia=80000020, in_handler=0.
//  4 RUN, ia=80000040, irq=1 (no sync) -> ia=80000008, xp=80000044, irq_ack 1 cycle;
//    irq held high in HANDLER -> no second ack; eret -> ia=80000044, next cycle irq taken.
//  5 In HANDLER, Exception=1 -> ia=80000000, double_fault=1, xp unchanged; stays 1
//    until reset_n=0.
//  6 ia=FFFFFFFC sequential -> ia=0; reset_n=0 same cycle as Exception+irq -> ia=80000000,
//    all outputs reset. With PC_SEQ_IRQ_SYNC_EN: irq rise -> taken on 3rd posedge.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared vectors, state/select enums and helpers for the next-PC sequencer.
package pc_seq_pkg;

  localparam logic [31:0] RESET_VEC_DEF = 32'h8000_0000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h8000_0004;
  localparam logic [31:0] IRQ_VEC_DEF   = 32'h8000_0008;

  typedef enum logic {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } pc_seq_state_e;

  // PC_HOLD covers the stall case, where ia is simply kept.
  typedef enum logic [2:0] {
    PC_SEQ  = 3'd0,
    PC_BR   = 3'd1,
    PC_JMP  = 3'd2,
    PC_XP   = 3'd3,
    PC_EXC  = 3'd4,
    PC_IRQ  = 3'd5,
    PC_RST  = 3'd6,
    PC_HOLD = 3'd7
  } pc_sel_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/pc_seq_ctrl_irq_sync.sv
// Two-flop synchronizer for the external interrupt level; used by pc_seq_ctrl
// only when PC_SEQ_IRQ_SYNC_EN is defined.
module pc_seq_ctrl_irq_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/pc_seq_ctrl.sv
// Next-PC sequencer and trap controller: owns ia/xp and the RUN/HANDLER mode.
// Define PC_SEQ_IRQ_SYNC_EN to route irq through a 2-flop synchronizer.
module pc_seq_ctrl
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF,
  parameter logic [31:0] IRQ_VEC   = IRQ_VEC_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          stall,
  input  logic          branch_taken,
  input  logic [31:0]   branch_target,
  input  logic          jump,
  input  logic [31:0]   jump_target,
  input  logic          eret,
  input  logic          Exception,
  input  logic          irq,
  output logic [31:0]   ia,
  output logic [31:0]   xp,
  output logic          in_handler,
  output logic          irq_ack,
  output logic          double_fault,
  output pc_seq_state_e state_dbg
);

  pc_seq_state_e state_q, state_d;
  logic [31:0]   ia_q, ia_d;
  logic [31:0]   xp_q, xp_d;
  logic          ack_q, ack_d;
  logic          df_q, df_d;
  logic          irq_eff;
  pc_sel_e       pc_sel;

`ifdef PC_SEQ_IRQ_SYNC_EN
  pc_seq_ctrl_irq_sync u_irq_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (irq),
    .sync_o  (irq_eff)
  );
`else
  assign irq_eff = irq;
`endif

  // Priority: Exception > irq (RUN, unstalled) > stall > eret > jump > branch > seq.
  always_comb begin
    pc_sel = PC_SEQ;
    if (Exception)
      pc_sel = (state_q == HANDLER) ? PC_RST : PC_EXC;
    else if (irq_eff && (state_q == RUN) && !stall)
      pc_sel = PC_IRQ;
    else if (stall)
      pc_sel = PC_HOLD;
    else if (eret && (state_q == HANDLER))
      pc_sel = PC_XP;
    else if (jump)
      pc_sel = PC_JMP;
    else if (branch_taken)
      pc_sel = PC_BR;
  end

  always_comb begin
    ia_d    = ia_q + 32'd4;
    xp_d    = xp_q;
    state_d = state_q;
    ack_d   = 1'b0;
    df_d    = df_q;
    case (pc_sel)
      PC_EXC: begin
        xp_d    = ia_q;
        ia_d    = EXC_VEC;
        state_d = HANDLER;
      end
      PC_RST: begin
        df_d    = 1'b1;
        ia_d    = RESET_VEC;
        state_d = RUN;
      end
      PC_IRQ: begin
        xp_d    = ia_q + 32'd4;
        ia_d    = IRQ_VEC;
        ack_d   = 1'b1;
        state_d = HANDLER;
      end
      PC_HOLD: ia_d = ia_q;
      PC_XP: begin
        ia_d    = xp_q;
        state_d = RUN;
      end
      PC_JMP:  ia_d = word_align(jump_target);
      PC_BR:   ia_d = word_align(branch_target);
      default: ia_d = ia_q + 32'd4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= RUN;
      ia_q    <= RESET_VEC;
      xp_q    <= 32'd0;
      ack_q   <= 1'b0;
      df_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ia_q    <= ia_d;
      xp_q    <= xp_d;
      ack_q   <= ack_d;
      df_q    <= df_d;
    end
  end

  assign ia           = ia_q;
  assign xp           = xp_q;
  assign in_handler   = (state_q == HANDLER);
  assign irq_ack      = ack_q;
  assign double_fault = df_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_pc_seq_ctrl;
  import pc_seq_pkg::*;

  localparam logic [31:0] R_VEC = 32'h8000_0000;
  localparam logic [31:0] E_VEC = 32'h8000_0004;
  localparam logic [31:0] I_VEC = 32'h8000_0008;
`ifdef PC_SEQ_IRQ_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset_n;
  logic          stall, branch_taken, jump, eret, Exception, irq;
  logic [31:0]   branch_target, jump_target;
  logic [31:0]   ia, xp;
  logic          in_handler, irq_ack, double_fault;
  pc_seq_state_e state_dbg;

  always #5 clk = ~clk;

  pc_seq_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .eret          (eret),
    .Exception     (Exception),
    .irq           (irq),
    .ia            (ia),
    .xp            (xp),
    .in_handler    (in_handler),
    .irq_ack       (irq_ack),
    .double_fault  (double_fault),
    .state_dbg     (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_ia, m_xp;
  logic        m_handler, m_ack, m_df;
  logic        m_valid = 1'b0;
  logic        irq_hist[$];

  always @(posedge clk) begin
    logic irq_seen;
    // The core reacts to the irq level as it was SYNC_LAT samples ago.
    irq_hist.push_back(irq);
    if (irq_hist.size() > SYNC_LAT + 1) void'(irq_hist.pop_front());
    irq_seen = (irq_hist.size() == SYNC_LAT + 1) ? irq_hist[0] : 1'b0;
    if (!reset_n) begin
      m_ia = R_VEC; m_xp = 32'd0; m_handler = 1'b0; m_ack = 1'b0; m_df = 1'b0;
      m_valid = 1'b1;
      irq_hist.delete();
      for (int i = 0; i < SYNC_LAT; i++) irq_hist.push_back(1'b0);
    end else begin
      m_ack = 1'b0;
      if (Exception) begin
        if (m_handler) begin
          m_df = 1'b1; m_ia = R_VEC; m_handler = 1'b0;
        end else begin
          m_xp = m_ia; m_ia = E_VEC; m_handler = 1'b1;
        end
      end else if (irq_seen && !m_handler && !stall) begin
        m_xp = m_ia + 32'd4; m_ia = I_VEC; m_handler = 1'b1; m_ack = 1'b1;
      end else if (stall) begin
        m_ia = m_ia;
      end else if (eret && m_handler) begin
        m_ia = m_xp; m_handler = 1'b0;
      end else if (jump) begin
        m_ia = {jump_target[31:2], 2'b00};
      end else if (branch_taken) begin
        m_ia = {branch_target[31:2], 2'b00};
      end else begin
        m_ia = m_ia + 32'd4;
      end
    end
  end

  // ---------------- scoreboard compare process ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_ia", ia, m_ia);
      chk("model_xp", xp, m_xp);
      chk("model_in_handler", {31'd0, in_handler}, {31'd0, m_handler});
      chk("model_irq_ack", {31'd0, irq_ack}, {31'd0, m_ack});
      chk("model_double_fault", {31'd0, double_fault}, {31'd0, m_df});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; eret = 1'b0;
    Exception = 1'b0; branch_target = 32'd0; jump_target = 32'd0;
  endtask

  task automatic do_jump(input logic [31:0] t);
    jump = 1'b1; jump_target = t;
    cyc();
    jump = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; irq = 1'b0;
    idle_inputs();
    cyc(); cyc();
    chk("rst_ia", ia, R_VEC);
    chk("rst_xp", xp, 32'd0);
    chk("rst_flags", {29'd0, in_handler, irq_ack, double_fault}, 32'd0);

    reset_n = 1'b1;
    cyc(); chk("seq_1", ia, 32'h8000_0004);
    cyc(); chk("seq_2", ia, 32'h8000_0008);
    cyc(); chk("seq_3", ia, 32'h8000_000C);
    cyc(); chk("seq_4", ia, 32'h8000_0010);

    branch_taken = 1'b1; branch_target = 32'h100; jump = 1'b1; jump_target = 32'h200;
    cyc(); chk("jump_beats_branch", ia, 32'h200);
    jump = 1'b0; branch_target = 32'h103;
    cyc(); chk("branch_aligned", ia, 32'h100);
    branch_taken = 1'b0;

    do_jump(32'h8000_0020);
    Exception = 1'b1; stall = 1'b1;
    cyc();
    chk("exc_ia", ia, E_VEC);
    chk("exc_xp", xp, 32'h8000_0020);
    chk("exc_in_handler", {31'd0, in_handler}, 32'd1);
    Exception = 1'b0; stall = 1'b0; eret = 1'b1;
    cyc();
    chk("eret_ia", ia, 32'h8000_0020);
    chk("eret_in_handler", {31'd0, in_handler}, 32'd0);
    eret = 1'b0;

    do_jump(32'h8000_0040);
    irq = 1'b1; stall = 1'b1;
    for (int i = 0; i < SYNC_LAT; i++) cyc();
    stall = 1'b0;
    cyc();
    chk("irq_ia", ia, I_VEC);
    chk("irq_xp", xp, 32'h8000_0044);
    chk("irq_ack_pulse", {31'd0, irq_ack}, 32'd1);
    cyc();
    chk("irq_masked_no_ack", {31'd0, irq_ack}, 32'd0);
    chk("handler_seq", ia, 32'h8000_000C);
    eret = 1'b1;
    cyc();
    chk("eret_irq_pending_ia", ia, 32'h8000_0044);
    eret = 1'b0;
    cyc();
    chk("irq_retaken_ia", ia, I_VEC);
    chk("irq_retaken_xp", xp, 32'h8000_0048);
    chk("irq_retaken_ack", {31'd0, irq_ack}, 32'd1);
    irq = 1'b0;
    cyc();

    Exception = 1'b1;
    cyc();
    chk("dfault_ia", ia, R_VEC);
    chk("dfault_flag", {31'd0, double_fault}, 32'd1);
    chk("dfault_xp_kept", xp, 32'h8000_0048);
    Exception = 1'b0;
    cyc(); cyc();
    chk("dfault_sticky", {31'd0, double_fault}, 32'd1);

    do_jump(32'hFFFF_FFFC);
    cyc();
    chk("wrap_ia", ia, 32'd0);
    reset_n = 1'b0; Exception = 1'b1; irq = 1'b1; stall = 1'b1;
    cyc();
    chk("rst_over_all_ia", ia, R_VEC);
    chk("rst_over_all_flags", {28'd0, in_handler, irq_ack, double_fault, 1'b0}, 32'd0);
    reset_n = 1'b1; irq = 1'b0;
    idle_inputs();

    for (int n = 0; n < 3000; n++) begin
      reset_n       = ($urandom_range(0, 99) != 0);
      stall         = ($urandom_range(0, 3) == 0);
      Exception     = ($urandom_range(0, 19) == 0);
      irq           = ($urandom_range(0, 3) == 0);
      eret          = ($urandom_range(0, 5) == 0);
      jump          = ($urandom_range(0, 5) == 0);
      branch_taken  = ($urandom_range(0, 3) == 0);
      jump_target   = $urandom;
      branch_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
